// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and MUL/DIV results onto the single regfile write port.
// Each source has a one-entry buffer; the oldest buffered entry wins and the output stage is registered.
package wb_arbiter_pkg;
  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] word_t;
  typedef logic [3:0]  age_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t wa;
    word_t      wd;
    age_t       age;
  } wb_buf_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  creg_addr_t  alu_wa,
  input  word_t       alu_wd,
  output logic        alu_ready,
  input  logic        md_valid,
  input  creg_addr_t  md_wa,
  input  word_t       md_wd,
  output logic        md_ready,
  output logic        wen,
  output creg_addr_t  wa,
  output word_t       wd,
  output logic [31:0] pending
);

  wb_buf_t    alu_q, alu_d, md_q, md_d;
  age_t       seq_q, seq_d;
  logic       wen_q, wen_d;
  creg_addr_t wa_q, wa_d;
  word_t      wd_q, wd_d;

  age_t       age_diff;
  logic       alu_older, gnt_alu, gnt_md, gnt_any;
  logic       alu_fire, md_fire;
  creg_addr_t g_wa;
  word_t      g_wd;

  // Stamps only advance on capture and an entry waits at most one cycle,
  // so the wrapped difference of two live stamps is always small.
  assign age_diff  = alu_q.age - md_q.age;
  assign alu_older = age_diff[3];

  assign gnt_alu = alu_q.valid && (!md_q.valid || alu_older);
  assign gnt_md  = md_q.valid && !gnt_alu;
  assign gnt_any = gnt_alu || gnt_md;

  assign alu_ready = !reset && (!alu_q.valid || gnt_alu);
  assign md_ready  = !reset && (!md_q.valid || gnt_md);
  assign alu_fire  = alu_valid && alu_ready;
  assign md_fire   = md_valid && md_ready;

  assign g_wa = gnt_alu ? alu_q.wa : md_q.wa;
  assign g_wd = gnt_alu ? alu_q.wd : md_q.wd;

  always_comb begin
    alu_d = alu_q;
    md_d  = md_q;
    seq_d = seq_q;
    wen_d = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;

    if (gnt_alu) alu_d.valid = 1'b0;
    if (gnt_md)  md_d.valid  = 1'b0;

    // A capture overrides the grant-clear, which gives same-edge refill.
    if (alu_fire) alu_d = '{valid: 1'b1, wa: alu_wa, wd: alu_wd, age: seq_q};
    if (md_fire)  md_d  = '{valid: 1'b1, wa: md_wa,  wd: md_wd,  age: seq_q};
    if (alu_fire || md_fire) seq_d = seq_q + age_t'(1);

    // x0 writes are consumed but squashed to an all-zero idle write.
    if (gnt_any) begin
      wen_d = (g_wa != '0);
      wa_d  = (g_wa != '0) ? g_wa : '0;
      wd_d  = (g_wa != '0) ? g_wd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q <= '0;
      md_q  <= '0;
      seq_q <= '0;
      wen_q <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      alu_q <= alu_d;
      md_q  <= md_d;
      seq_q <= seq_d;
      wen_q <= wen_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

  assign wen = wen_q;
  assign wa  = wa_q;
  assign wd  = wd_q;

  always_comb begin
    pending = '0;
    if (alu_q.valid) pending[alu_q.wa] = 1'b1;
    if (md_q.valid)  pending[md_q.wa]  = 1'b1;
    if (wen_q)       pending[wa_q]     = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high; sampled only on rising edge of clk.
REQ-003 SHALL have ports alu_valid (input, 1), alu_wa (input, 5, creg_addr_t), alu_wd (input, 64, word_t) and alu_ready (output, 1): ALU result source.
REQ-004 SHALL have ports md_valid (input, 1), md_wa (input, 5, creg_addr_t), md_wd (input, 64, word_t) and md_ready (output, 1): multiply/divide result source.
REQ-005 SHALL have ports wen (output, 1), wa (output, 5, creg_addr_t) and wd (output, 64, word_t): regfile write port, connected directly to regfile wen/wa/wd.
REQ-006 SHALL have port pending, output, 32, one bit per architectural register with a write buffered or in flight, for hazard detection.

Function
REQ-007 SHALL hold one single-entry buffer per source (ALU, MD), each with fields valid, wa, wd and an age stamp.
REQ-008 SHALL complete a source handshake on a rising edge where x_valid && x_ready; the buffer captures wa/wd on that edge.
REQ-009 SHALL drive x_ready = !reset && (buffer empty || buffer granted this cycle), combinationally; a source may therefore transfer back-to-back every cycle.
REQ-010 SHALL keep x_valid, x_wa and x_wd stable from the producer while x_ready is low; wb_arbiter does not check this.
REQ-011 SHALL grant at most one buffer per cycle; the sole occupied buffer is granted.
REQ-012 SHALL grant the older entry when both buffers are occupied; if both were captured on the same edge, MD wins.
REQ-013 SHALL register the grant: wen, wa and wd update on the edge ending the grant cycle, and the granted buffer empties on that same edge.
REQ-014 SHALL give a latency of exactly 2 edges: handshake at edge k, wen high between edges k+1 and k+2, regfile commit at edge k+2, unless the entry loses arbitration.
REQ-015 SHALL drive wen = 0 in any cycle following a cycle with no grant; wa and wd hold their last values.
REQ-016 SHALL consume a granted entry with wa == 0 as a normal grant, but drive wen = 0 and wa/wd = 0 for it, so that x0 is never written.
REQ-017 SHALL ensure that two buffered writes to the same register commit in age order, so the younger value is the final regfile content.
REQ-018 SHALL compute pending as the OR of onehot(wa) over occupied buffers and over the output stage when wen = 1; bit 0 is always 0.
REQ-019 SHALL deassert the pending bit for a register on the edge at which the regfile commits it, unless another write to that register is still buffered.
REQ-020 SHALL allow a buffer to be captured and granted-out on the same edge (refill); the new entry gets a fresh age stamp that is younger than the other buffer.

Reset
REQ-021 SHALL, while reset is high at an edge, empty both buffers, clear the age state, and set wen = 0, wa = 0, wd = 0.
REQ-022 SHALL hold alu_ready = md_ready = 0 while reset is high; handshakes attempted during reset are discarded.
REQ-023 SHALL discard all buffered and in-flight entries when reset is asserted mid-operation; no write reaches the regfile after the reset edge.
REQ-024 SHALL drive pending = 0 on the cycle after reset and resume normal operation on the first edge with reset low.

Verification
REQ-025 SHALL verify single write: ALU handshake at edge 1 with wa=5, wd=0x1234 -> wen=1, wa=5, wd=0x1234 between edges 2 and 3; pending[5]=1 from edge 1 to edge 3.
REQ-026 SHALL verify collision: ALU (wa=3, wd=0xA) and MD (wa=3, wd=0xB) captured on the same edge -> MD writes first, then ALU on the next cycle; the final regfile x3 = 0xA; alu_ready=0 for one cycle.
REQ-027 SHALL verify age order: MD handshake (wa=7) at edge 1, ALU handshake (wa=8) at edge 2 -> x7 writes before x8.
REQ-028 SHALL verify x0 drop: ALU handshake with wa=0, wd=0xFFFF -> wen stays 0 throughout, and alu_ready stays 1.
REQ-029 SHALL verify streaming: ALU valid held high for 8 cycles with distinct wa=1..8 and MD idle -> 8 consecutive cycles with wen=1, in order, and alu_ready constantly 1.
REQ-030 SHALL verify mid-reset: both buffers full, then reset high for one edge -> wen=0, pending=0, and the ready outputs low during reset; neither value reaches the regfile.
